// File: rtl/reg_bus_xfer_ctrl.sv
// Sequencer for a bank of bus registers: MOV, LDI, SWAP and CLR through temp latches.
// Strobes are decoded from registered state only, so a register read and our own bus drive never overlap.
module reg_bus_xfer_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int NREG   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_a,
  input  logic [ADDR_W-1:0] cmd_b,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic [NREG-1:0]   rd_en,
  output logic [NREG-1:0]   wr_en,
  output logic              busy,
  output logic              done,
  output logic [7:0]        xfer_count
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B} state_e;
  typedef enum logic [1:0] {OP_MOV = 2'b00, OP_LDI = 2'b01, OP_SWAP = 2'b10, OP_CLR = 2'b11} op_e;

  state_e              state_q;
  op_e                 op_q;
  logic [ADDR_W-1:0]   a_q, b_q;
  logic [DATA_W-1:0]   tmp0_q, tmp1_q;
  logic                done_q;
  logic [7:0]          count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MOV;
      a_q     <= '0;
      b_q     <= '0;
      tmp0_q  <= '0;
      tmp1_q  <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q <= op_e'(cmd_op);
            a_q  <= cmd_a;
            b_q  <= cmd_b;
            unique case (op_e'(cmd_op))
              OP_MOV, OP_SWAP: state_q <= RD_A;
              OP_LDI: begin
                tmp0_q  <= cmd_imm;
                state_q <= WR_B;
              end
              OP_CLR: begin
                tmp0_q  <= '0;
                state_q <= WR_B;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
        RD_A: begin
          tmp0_q  <= bus_in;
          state_q <= (op_q == OP_SWAP) ? RD_B : WR_B;
        end
        RD_B: begin
          tmp1_q  <= bus_in;
          state_q <= WR_A;
        end
        WR_A: state_q <= WR_B;
        WR_B: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          count_q <= count_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // WR_A writes back the second-read value into a; every other write uses tmp0.
  always_comb begin
    rd_en   = '0;
    wr_en   = '0;
    bus_oe  = 1'b0;
    bus_out = tmp0_q;
    unique case (state_q)
      RD_A: rd_en[a_q] = 1'b1;
      RD_B: rd_en[b_q] = 1'b1;
      WR_A: begin
        bus_oe     = 1'b1;
        bus_out    = tmp1_q;
        wr_en[a_q] = 1'b1;
      end
      WR_B: begin
        bus_oe     = 1'b1;
        wr_en[b_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_reg_bus_xfer_ctrl.sv
// Directed bench for reg_bus_xfer_ctrl with a behavioural 32x8 register bank on the shared bus.
module tb_reg_bus_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [4:0]  cmd_a = '0, cmd_b = '0;
  logic [7:0]  cmd_imm = '0;
  logic [7:0]  bus_in, bus_out;
  logic        bus_oe;
  logic [31:0] rd_en, wr_en;
  logic        busy, done;
  logic [7:0]  xfer_count;

  logic [7:0]  regs [32];
  int checks = 0;
  int errors = 0;
  int viol = 0;

  localparam logic [1:0] MOV = 2'b00, LDI = 2'b01, SWAP = 2'b10, CLR = 2'b11;

  always #5 clk = ~clk;

  reg_bus_xfer_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_imm(cmd_imm),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .rd_en(rd_en), .wr_en(wr_en), .busy(busy), .done(done), .xfer_count(xfer_count)
  );

  // Register bank: the selected register drives the bus when read-enabled.
  always_comb begin
    bus_in = bus_oe ? bus_out : 8'h00;
    for (int i = 0; i < 32; i++)
      if (rd_en[i]) bus_in = regs[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 32; i++)
      if (wr_en[i] && bus_oe) regs[i] <= bus_out;
  end

  always @(negedge clk) begin
    if (($countones(rd_en | wr_en) > 1) || (bus_oe && (rd_en != 32'h0)) ||
        (!busy && (bus_oe || ((rd_en | wr_en) != 32'h0))))
      viol++;
  end

  task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b, input logic [7:0] imm);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_imm = imm;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL send_accept: cmd_ready=%b, required 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (done !== 1'b1 && cyc < limit);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL wait_done: no done within %0d cycles", limit); end
  endtask

  task automatic run(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b, input logic [7:0] imm);
    int cyc;
    send(op, a, b, imm);
    wait_done(10, cyc);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, bus_oe, done} !== 4'b1000) begin errors++; $display("FAIL reset_ctl: ready/busy/oe/done=%b, required 1000", {cmd_ready, busy, bus_oe, done}); end
    checks++;
    if ((rd_en | wr_en) !== 32'h0) begin errors++; $display("FAIL reset_strobes: got %h, required 0", rd_en | wr_en); end
    checks++;
    if (xfer_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", xfer_count); end
  endtask

  task automatic test_ldi;
    send(LDI, 5'd0, 5'd5, 8'hA5);
    @(negedge clk);
    checks++;
    if (wr_en !== 32'h0000_0020 || bus_oe !== 1'b1 || bus_out !== 8'hA5 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL ldi_wr_b: wr_en=%h oe=%b bus=%h ready=%b, required 00000020 1 a5 0", wr_en, bus_oe, bus_out, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || xfer_count !== 8'd1 || regs[5] !== 8'hA5) begin
      errors++; $display("FAIL ldi_done: done=%b count=%0d r5=%h, required 1 1 a5", done, xfer_count, regs[5]);
    end
  endtask

  task automatic test_mov;
    run(LDI, 5'd0, 5'd3, 8'h3C);
    send(MOV, 5'd3, 5'd7, 8'h00);
    @(negedge clk);
    checks++;
    if (rd_en !== 32'h0000_0008 || bus_oe !== 1'b0) begin errors++; $display("FAIL mov_rd_a: rd_en=%h oe=%b, required 00000008 0", rd_en, bus_oe); end
    @(negedge clk);
    checks++;
    if (wr_en !== 32'h0000_0080 || bus_oe !== 1'b1 || bus_out !== 8'h3C) begin
      errors++; $display("FAIL mov_wr_b: wr_en=%h oe=%b bus=%h, required 00000080 1 3c", wr_en, bus_oe, bus_out);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || regs[7] !== 8'h3C || regs[3] !== 8'h3C || xfer_count !== 8'd3) begin
      errors++; $display("FAIL mov_done: done=%b r7=%h r3=%h count=%0d, required 1 3c 3c 3", done, regs[7], regs[3], xfer_count);
    end
  endtask

  task automatic test_swap;
    run(LDI, 5'd0, 5'd1, 8'h11);
    run(LDI, 5'd0, 5'd2, 8'h22);
    send(SWAP, 5'd1, 5'd2, 8'h00);
    @(negedge clk);
    checks++;
    if (rd_en !== 32'h2 || bus_oe !== 1'b0) begin errors++; $display("FAIL swap_rd_a: rd_en=%h oe=%b, required 00000002 0", rd_en, bus_oe); end
    @(negedge clk);
    checks++;
    if (rd_en !== 32'h4 || bus_oe !== 1'b0) begin errors++; $display("FAIL swap_rd_b: rd_en=%h oe=%b, required 00000004 0", rd_en, bus_oe); end
    @(negedge clk);
    checks++;
    if (wr_en !== 32'h2 || bus_out !== 8'h22 || bus_oe !== 1'b1) begin errors++; $display("FAIL swap_wr_a: wr_en=%h bus=%h oe=%b, required 00000002 22 1", wr_en, bus_out, bus_oe); end
    @(negedge clk);
    checks++;
    if (wr_en !== 32'h4 || bus_out !== 8'h11 || bus_oe !== 1'b1) begin errors++; $display("FAIL swap_wr_b: wr_en=%h bus=%h oe=%b, required 00000004 11 1", wr_en, bus_out, bus_oe); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || regs[1] !== 8'h22 || regs[2] !== 8'h11) begin
      errors++; $display("FAIL swap_done: done=%b r1=%h r2=%h, required 1 22 11", done, regs[1], regs[2]);
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL swap_contention: %0d strobe violations, required 0", viol); end
  endtask

  task automatic test_back_to_back;
    run(LDI, 5'd0, 5'd0, 8'h77);
    run(LDI, 5'd0, 5'd31, 8'hFF);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = CLR; cmd_a = 5'd0; cmd_b = 5'd0; cmd_imm = 8'h00;
    @(posedge clk); #1;
    cmd_op = MOV; cmd_a = 5'd0; cmd_b = 5'd31;
    @(negedge clk);
    checks++;
    if (wr_en !== 32'h1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_clr: wr_en=%h ready=%b, required 00000001 0", wr_en, cmd_ready); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || regs[0] !== 8'h00) begin
      errors++; $display("FAIL b2b_handover: done=%b ready=%b r0=%h, required 1 1 00", done, cmd_ready, regs[0]);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_en !== 32'h1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_mov_rd: rd_en=%h ready=%b, required 00000001 0", rd_en, cmd_ready); end
    @(negedge clk);
    checks++;
    if (wr_en !== 32'h8000_0000 || bus_out !== 8'h00 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_mov_wr: wr_en=%h bus=%h ready=%b, required 80000000 00 0", wr_en, bus_out, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || regs[31] !== 8'h00) begin errors++; $display("FAIL b2b_mov_done: done=%b r31=%h, required 1 00", done, regs[31]); end
  endtask

  task automatic test_reset_abort;
    send(SWAP, 5'd1, 5'd2, 8'h00);
    @(negedge clk);
    checks++;
    if (rd_en !== 32'h2) begin errors++; $display("FAIL abort_rd_a: rd_en=%h, required 00000002", rd_en); end
    @(negedge clk);
    checks++;
    if (rd_en !== 32'h4) begin errors++; $display("FAIL abort_rd_b: rd_en=%h, required 00000004", rd_en); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ((rd_en | wr_en) !== 32'h0 || bus_oe !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL abort_idle: strobes=%h oe=%b busy=%b ready=%b, required 0 0 0 1", rd_en | wr_en, bus_oe, busy, cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (done !== 1'b0 || wr_en !== 32'h0) begin errors++; $display("FAIL abort_no_done: cycle %0d done=%b wr_en=%h, required 0 0", i, done, wr_en); end
      @(negedge clk);
    end
    checks++;
    if (regs[1] !== 8'h22 || regs[2] !== 8'h11 || xfer_count !== 8'd0) begin
      errors++; $display("FAIL abort_state: r1=%h r2=%h count=%0d, required 22 11 0", regs[1], regs[2], xfer_count);
    end
  endtask

  task automatic test_wrap_and_self_swap;
    int cyc;
    run(LDI, 5'd0, 5'd9, 8'h5A);
    for (int i = 0; i < 255; i++) run(LDI, 5'd0, 5'd10, 8'(i));
    checks++;
    if (xfer_count !== 8'd0 || regs[10] !== 8'hFE) begin errors++; $display("FAIL wrap: count=%0d r10=%h, required 0 fe", xfer_count, regs[10]); end
    send(SWAP, 5'd9, 5'd9, 8'h00);
    wait_done(10, cyc);
    checks++;
    if (cyc !== 5 || regs[9] !== 8'h5A || xfer_count !== 8'd1) begin
      errors++; $display("FAIL self_swap: done_cycle=%0d r9=%h count=%0d, required 5 5a 1", cyc, regs[9], xfer_count);
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL strobe_rules: %0d violations, required 0", viol); end
  endtask

  initial begin
    test_reset;
    test_ldi;
    test_mov;
    test_swap;
    test_back_to_back;
    test_reset_abort;
    test_wrap_and_self_swap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
